cmp_iter_nbit: RTL and testbench
================================

Name: cmp_iter_nbit

Overview:
- Parametrised, multi-cycle successor to the fixed 32-bit unsigned comparator.
- Compares two WIDTH-bit operands one CHUNK-bit slice per cycle, starting at the most-significant chunk, and stops at the first chunk that differs.
- Supports signed and unsigned modes per operation, with a start/ready/done handshake and an abort.
- Used by multi-cycle execute paths (e.g. long-operand branch/compare units) where a full-width single-cycle comparator does not meet timing.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; 1 <= CHUNK <= WIDTH.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- start_i  in  1  request; accepted only when start_i && ready_o.
- signed_i  in  1  1 = two's-complement compare, 0 = unsigned; sampled at accept.
- abort_i  in  1  cancel any in-flight operation.
- a_i  in  WIDTH  operand A; sampled at accept.
- b_i  in  WIDTH  operand B; sampled at accept.
- ready_o  out  1  high only in IDLE.
- busy_o  out  1  high in SCAN.
- done_o  out  1  one-cycle pulse; result valid.
- equal_o  out  1  A == B.
- alarger_o  out  1  A > B.
- blarger_o  out  1  A < B.

Behaviour:
- NCHUNK = WIDTH/CHUNK. Chunk index register idx has width max(1, $clog2(NCHUNK)).
- Reset (asynchronous, any state): state = IDLE, idx = NCHUNK-1, operand registers = 0, done_o = 0, busy_o = 0, all result outputs = 0. ready_o = 1 as soon as reset deasserts.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - On start_i && !abort_i: capture a_i and b_i into registers. If signed_i = 1, invert bit WIDTH-1 of both captured operands (sign-bias), so the unsigned chunk compare gives the signed ordering.
  - Set idx = NCHUNK-1 and go to SCAN.
  - In all other cases, stay in IDLE.
- SCAN:
  - Compare chunk idx of A against chunk idx of B.
  - If the chunks differ: register alarger_o/blarger_o from that chunk compare, set equal_o = 0, go to DONE.
  - Else, if idx == 0: register equal_o = 1 and alarger_o = blarger_o = 0, go to DONE.
  - Else: decrement idx and stay in SCAN.
- DONE:
  - done_o = 1 for exactly this one cycle, then go to IDLE.
  - start_i is ignored in DONE because ready_o = 0.
- Result outputs are one-hot (or all 0 only after reset). They hold their value from DONE until the next completed operation. They are not cleared at accept or at abort.
- Latency: if the operation is accepted in cycle T and k chunks are scanned (1..NCHUNK), done_o is high in cycle T+1+k.
  - For WIDTH=32, CHUNK=8: minimum T+2, maximum T+5.
- Throughput: at most one accept every k+2 cycles; the next accept can happen in the IDLE cycle right after DONE.
- Abort:
  - abort_i in SCAN or DONE forces IDLE on the next edge. No done_o pulse follows, and any done_o in the abort cycle still shows as asserted.
  - abort_i has priority over start_i in IDLE: the request is not accepted.
- NCHUNK = 1 degenerates to a single SCAN cycle, so done_o is always at T+2.
- Changing a_i, b_i or signed_i after accept has no effect on the operation in flight.

Decomposition:
- Package cmp_pkg holds:
  - the state enum typedef (IDLE/SCAN/DONE);
  - a localparam helper function for NCHUNK and the idx width;
  - the elaboration-time check that WIDTH % CHUNK == 0.
- Sub-module cmp_chunk: purely combinational, parameter W. Inputs a, b; outputs eq and gt. Instantiated once on the idx-selected slice.
- The FSM, operand registers and result registers live in cmp_iter_nbit.

Test Plan:
- Top-chunk difference (WIDTH=32, CHUNK=8): unsigned, a=0xFFFFFFFF, b=0x00000001, accept at T -> done_o at T+2 with alarger_o=1; repeat with signed_i=1 -> blarger_o=1 (-1 < 1).
- Equal operands: a=b=0x12345678 -> done_o at T+5, equal_o=1, the other two outputs 0; busy_o high for cycles T+1..T+4.
- Bottom-chunk difference: a=0x00000010, b=0x00000011 -> done_o at T+5, blarger_o=1. Signed case a=0x80000000, b=0x7FFFFFFF -> blarger_o=1 at T+2.
- Abort: start a=b=0, assert abort_i in T+2 -> IDLE at T+3, ready_o=1, no done_o pulse, results keep previous values; start_i and abort_i together in IDLE -> no accept.
- Back-to-back with start_i held high: second accept occurs in the cycle after the done_o pulse; operands changed after accept do not alter the first result.
- Reset mid-SCAN: assert rst_i asynchronously at T+2 -> outputs 0 immediately, ready_o=1 after release; then CHUNK=32 (NCHUNK=1) instance -> done_o always at T+2.

Source files
------------

// File: rtl/cmp_iter_nbit_pkg.sv
// ----------------------------------------------------------------------------
// cmp_pkg
// Shared types and elaboration helpers for the iterative chunked comparator.
//   state_t  : FSM encoding (IDLE / SCAN / DONE)
//   nchunk() : number of CHUNK-bit slices in a WIDTH-bit operand
//   idx_w()  : width of the chunk index register, never below 1
//   cfg_ok() : legal WIDTH/CHUNK pairing, evaluated at elaboration
// ----------------------------------------------------------------------------
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk operand still needs a 1-bit index register.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit cfg_ok(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/cmp_iter_nbit_if.sv
// ----------------------------------------------------------------------------
// cmp_iter_nbit_if
// Request/result bundle of the iterative comparator.
//   start_i, signed_i, abort_i, a_i, b_i : request side (driven by master)
//   ready_o, busy_o, done_o              : handshake status (driven by slave)
//   equal_o, alarger_o, blarger_o        : one-hot result (driven by slave)
// ----------------------------------------------------------------------------
interface cmp_iter_nbit_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             signed_i;
    logic             abort_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             ready_o;
    logic             busy_o;
    logic             done_o;
    logic             equal_o;
    logic             alarger_o;
    logic             blarger_o;

    modport master (
        output start_i, signed_i, abort_i, a_i, b_i,
        input  ready_o, busy_o, done_o, equal_o, alarger_o, blarger_o
    );

    modport slave (
        input  start_i, signed_i, abort_i, a_i, b_i,
        output ready_o, busy_o, done_o, equal_o, alarger_o, blarger_o
    );
endinterface

// File: rtl/cmp_iter_nbit_chunk.sv
// ----------------------------------------------------------------------------
// cmp_chunk
// Combinational unsigned compare of one W-bit slice.
//   a, b : slice operands
//   eq   : a == b
//   gt   : a >  b (unsigned)
// ----------------------------------------------------------------------------
module cmp_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq,
    output logic         gt
);
    assign eq = (a == b);
    assign gt = (a > b);
endmodule

// File: rtl/cmp_iter_nbit.sv
// ----------------------------------------------------------------------------
// cmp_iter_nbit
// Multi-cycle WIDTH-bit comparator. Walks the operands one CHUNK-bit slice per
// cycle from the most-significant end and stops at the first differing slice.
// Signed compares are turned into unsigned ones by flipping the sign bit of
// both operands at capture.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : cmp_iter_nbit_if slave (start/signed/abort/a/b in;
//           ready/busy/done/equal/alarger/blarger out)
// ----------------------------------------------------------------------------
module cmp_iter_nbit
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    cmp_iter_nbit_if.slave        bus
);
    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDXW   = idx_w(NCHUNK);

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("cmp_iter_nbit: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t                         state_q, state_d;
    logic [IDXW-1:0]                idx_q, idx_d;
    logic [NCHUNK-1:0][CHUNK-1:0]   a_q, a_d, b_q, b_d;
    logic                           eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;

    logic [CHUNK-1:0]               a_c, b_c;
    logic                           c_eq, c_gt;

    // Slice currently under inspection.
    if (NCHUNK == 1) begin : g_one
        assign a_c = a_q[0];
        assign b_c = b_q[0];
    end else begin : g_many
        assign a_c = a_q[idx_q];
        assign b_c = b_q[idx_q];
    end

    cmp_chunk #(.W(CHUNK)) u_chunk (
        .a  (a_c),
        .b  (b_c),
        .eq (c_eq),
        .gt (c_gt)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= IDXW'(NCHUNK - 1);
            a_q     <= '0;
            b_q     <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;

        unique case (state_q)
            IDLE: begin
                // abort wins over a simultaneous start
                if (bus.start_i && !bus.abort_i) begin
                    a_d = bus.a_i;
                    b_d = bus.b_i;
                    // Sign-bias: with the MSB inverted, unsigned ordering of
                    // the biased values equals two's-complement ordering.
                    if (bus.signed_i) begin
                        a_d[NCHUNK-1][CHUNK-1] = ~bus.a_i[WIDTH-1];
                        b_d[NCHUNK-1][CHUNK-1] = ~bus.b_i[WIDTH-1];
                    end
                    idx_d   = IDXW'(NCHUNK - 1);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else if (!c_eq) begin
                    eq_d    = 1'b0;
                    gt_d    = c_gt;
                    lt_d    = !c_gt;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - IDXW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ready is held low while reset is asserted and rises on release.
    assign bus.ready_o   = (state_q == IDLE) && !rst_i;
    assign bus.busy_o    = (state_q == SCAN);
    assign bus.done_o    = (state_q == DONE);
    assign bus.equal_o   = eq_q;
    assign bus.alarger_o = gt_q;
    assign bus.blarger_o = lt_q;

endmodule

// File: tb/tb_cmp_iter_nbit.sv
// ----------------------------------------------------------------------------
// tb_cmp_iter_nbit
// Directed bench for cmp_iter_nbit. Two instances share the same stimulus:
// dut0 (WIDTH=32, CHUNK=8) and dut1 (WIDTH=32, CHUNK=32, single chunk).
// Status word per DUT: {ready, busy, done, equal, alarger, blarger}.
// ----------------------------------------------------------------------------
module tb_cmp_iter_nbit;

    localparam logic [2:0] R_EQ = 3'b100;
    localparam logic [2:0] R_GT = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sel = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cmp_iter_nbit_if #(.WIDTH(32)) bus0 ();
    cmp_iter_nbit_if #(.WIDTH(32)) bus1 ();

    assign bus0.start_i = start;  assign bus1.start_i = start;
    assign bus0.signed_i = sgn;   assign bus1.signed_i = sgn;
    assign bus0.abort_i = abort;  assign bus1.abort_i = abort;
    assign bus0.a_i = a;          assign bus1.a_i = a;
    assign bus0.b_i = b;          assign bus1.b_i = b;

    cmp_iter_nbit #(.WIDTH(32), .CHUNK(8)) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0)
    );

    cmp_iter_nbit #(.WIDTH(32), .CHUNK(32)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    wire [5:0] st0 = {bus0.ready_o, bus0.busy_o, bus0.done_o,
                      bus0.equal_o, bus0.alarger_o, bus0.blarger_o};
    wire [5:0] st1 = {bus1.ready_o, bus1.busy_o, bus1.done_o,
                      bus1.equal_o, bus1.alarger_o, bus1.blarger_o};
    wire [5:0] st  = sel ? st1 : st0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts negedges after the accepting edge up to and including done.
    task automatic wait_done(output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (st[4]) nbusy++;
            if (st[3]) break;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] ai, input logic [31:0] bi,
                       input logic s, input int exp_lat, input logic [2:0] exp_res);
        int lat, nbusy;
        @(negedge clk);
        a = ai; b = bi; sgn = s; start = 1'b1;
        @(posedge clk);
        #1;
        // scramble inputs after accept; the result must not move
        start = 1'b0; a = ~ai; b = ~bi; sgn = ~s;
        wait_done(lat, nbusy);
        chk({tag, " lat"}, lat, exp_lat);
        chk({tag, " res"}, {29'd0, st[2:0]}, {29'd0, exp_res});
        chk({tag, " busy"}, nbusy, exp_lat - 1);
        @(negedge clk);
        chk({tag, " rdy"}, {31'd0, st[5]}, 32'd1);
    endtask

    initial begin
        int lat, nbusy;
        logic seen;

        // reset state
        #1;
        chk("rst outs", {26'd0, st0}, 32'd0);
        chk("rst outs1", {26'd0, st1}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst rel", {26'd0, st0}, 32'h20);

        // WIDTH=32, CHUNK=8
        run("top_u",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 2, R_GT);
        run("top_s",    32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 2, R_LT);
        run("eq",       32'h1234_5678, 32'h1234_5678, 1'b0, 5, R_EQ);
        run("bot",      32'h0000_0010, 32'h0000_0011, 1'b0, 5, R_LT);
        run("s_minmax", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 2, R_LT);
        run("s_posneg", 32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 2, R_GT);
        run("mid",      32'h0000_0100, 32'h0000_00FF, 1'b0, 4, R_GT);

        // abort in T+2: back to IDLE, no done, results held (GT)
        @(negedge clk);
        a = '0; b = '0; sgn = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        chk("abort busy", {29'd0, st[5:3]}, 32'b010);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort idle", {29'd0, st[5:3]}, 32'b100);
        chk("abort hold", {29'd0, st[2:0]}, {29'd0, R_GT});
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (st[3]) seen = 1'b1;
        end
        chk("abort nodone", {31'd0, seen}, 32'd0);

        // start together with abort in IDLE is refused
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_abort", {29'd0, st[5:3]}, 32'b100);

        // back-to-back with start held high
        @(negedge clk);
        a = 32'h0100_0000; b = 32'h0200_0000; sgn = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 a = 32'h5; b = 32'h5;
        @(negedge clk);
        chk("b2b busy1", {29'd0, st[5:3]}, 32'b010);
        @(negedge clk);
        chk("b2b done1", {28'd0, st[3:0]}, {28'd0, 1'b1, R_LT});
        @(negedge clk);
        chk("b2b rdy", {31'd0, st[5]}, 32'd1);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, nbusy);
        chk("b2b lat2", lat, 5);
        chk("b2b res2", {29'd0, st[2:0]}, {29'd0, R_EQ});

        // asynchronous reset in the middle of SCAN
        @(negedge clk);
        a = '0; b = '0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst mid", {26'd0, st0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst mid rel", {26'd0, st0}, 32'h20);

        // single-chunk instance: always done at T+2
        sel = 1'b1;
        run("n1_u",   32'h0000_0005, 32'h0000_0003, 1'b0, 2, R_GT);
        run("n1_s",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 2, R_LT);
        run("n1_ubig",32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 2, R_GT);
        run("n1_eq",  32'h0000_0007, 32'h0000_0007, 1'b0, 2, R_EQ);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
